mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage sequencer that produces the inputs and enables for the MEM/WB pipeline register.
- Takes EX/MEM outputs, issues data-cache requests, and waits for the dhit handshake.
- Freezes upstream stages and inserts bubbles into MEM/WB while waiting, then releases the completed load data with a one-cycle MEM/WB enable.
- Holds the LL/SC link register.

Parameters:
- DATA_W, 32, width of data words and addresses.
- LINK_EN, 1, when 1 implements LL/SC; when 0 SC always succeeds as a plain store.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- valid_i  in  1  instruction present in MEM
- dREN_i  in  1  load (LW or LL)
- dWEN_i  in  1  store (SW or SC)
- ll_i  in  1  load-linked
- sc_i  in  1  store-conditional (dWEN_i also high)
- addr_i  in  DATA_W  effective address
- store_i  in  DATA_W  store data
- halt_i  in  1  HALT in MEM
- dhit  in  1  cache access complete this cycle
- dmemload  in  DATA_W  cache read data, valid when dhit
- ccinv  in  1  coherence invalidate snoop
- ccaddr  in  DATA_W  snooped address
- dmemREN  out  1  cache read request
- dmemWEN  out  1  cache write request
- dmemaddr  out  DATA_W  request address
- dmemstore  out  DATA_W  request write data
- mem_stall  out  1  freeze PC/IF/ID/EX and EX/MEM
- mw_EN  out  1  MEM/WB enable
- mw_flush  out  1  MEM/WB bubble insert
- dmemload_o  out  DATA_W  data to MEM/WB dmemload_i
- halted  out  1  sticky halt

Behaviour:
- memop = valid_i & (dREN_i | dWEN_i) & ~halted.
- scfail = sc_i & LINK_EN & ~(link_valid & addr_i[31:2]==link_addr[31:2]).
- States: IDLE, ACCESS, DONE (mem_state_t).
- IDLE:
  - memop & ~scfail: mem_stall=1, mw_flush=1, mw_EN=0; next state ACCESS.
  - otherwise: mem_stall=0, mw_EN=1, mw_flush=0; stay IDLE.
  - scfail: single cycle, no cache access, dmemload_o=0, link cleared.
- ACCESS:
  - dmemREN=dREN_i, dmemWEN=dWEN_i, dmemaddr=addr_i, dmemstore=store_i; requests are a pure function of state and inputs.
  - mem_stall=1, mw_flush=1.
  - dhit=0: hold all request outputs stable.
  - dhit=1: load_r<=dmemload, next state DONE. Requests deassert at that edge.
- DONE:
  - mem_stall=0, mw_EN=1, mw_flush=0.
  - dmemload_o=load_r for loads; dmemload_o=1 for a successful SC.
  - Next state IDLE.
  - The next instruction enters MEM at this edge.
- Latency:
  - Memory op = 2 + N cycles, where N = cycles in ACCESS until dhit (N>=1).
  - Non-memop = 0 added cycles.
- Outside ACCESS: dmemREN=dmemWEN=0; dmemaddr=addr_i; dmemstore=store_i.
- dmemload_o in IDLE: 0, except scfail which is also 0 (SC result 0).
- Link register (link_valid, link_addr), all operations at state ACCESS & dhit:
  - LL load completes: link_valid<=1, link_addr<=addr_i.
  - Any store completes with word match: link_valid<=0.
  - SC completes: link_valid<=0.
  - ccinv & ccaddr[31:2]==link_addr[31:2], any cycle: link_valid<=0.
  - ccinv has priority over a simultaneous LL set. The link ends invalid.
- Halt:
  - valid_i & halt_i & state==IDLE: halted<=1 at the edge.
  - halted is sticky until reset; once set, memop=0 and no new requests are issued.
  - halt_i while in ACCESS is ignored; HALT cannot coexist with a memop.
- Reset (async, any state, including mid-ACCESS):
  - state=IDLE; load_r=0; link_valid=0; link_addr=0; halted=0.
  - All outputs read 0, except mw_EN=1 and the pass-through dmemaddr/dmemstore.
  - An abandoned request is dropped; the cache must tolerate REN falling without dhit.
- dhit outside ACCESS is ignored.
- All address comparisons are word-aligned (bits [31:2]).

Decomposition:
- cpu_types_pkg holds mem_state_t {IDLE, ACCESS, DONE} and word_t.
- One sub-module, ll_link_reg, holds link_valid/link_addr with its set/clear/snoop logic and the match output.

Test Plan:
- LW 0x100, dhit after 3 ACCESS cycles with dmemload=0xDEADBEEF:
  - mem_stall high for 4 cycles, mw_flush high for 4 cycles.
  - dmemREN high exactly 3 cycles.
  - DONE cycle: mw_EN=1, dmemload_o=0xDEADBEEF.
- SW 0x200 data 0x12345678, dhit on first ACCESS cycle:
  - dmemWEN one cycle, dmemaddr=0x200, dmemstore=0x12345678.
  - Total stall 2 cycles.
- LL 0x300 then SC 0x300 data 5 → SC result dmemload_o=1, dmemWEN asserted. A second SC to 0x300 → result 0, no dmemWEN, no stall.
- LL 0x300, then ccinv with ccaddr=0x302 → link cleared, next SC 0x300 returns 0. Repeat with ccaddr=0x304 → SC succeeds.
- Assert nRST low in ACCESS mid-LW:
  - Outputs return immediately to reset values, link_valid=0.
  - After release, a non-memop passes with mw_EN=1.
- HALT in IDLE → halted=1 next cycle. A following LW produces no dmemREN and no stall.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory-stage slice.
//   word_t      - one data word / address
//   mem_state_t - memory-stage sequencer states
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

endpackage

// File: rtl/ll_link_reg.sv
// ll_link_reg: LL/SC link register with snoop invalidation.
// Ports:
//   CLK, nRST   clock, asynchronous active-low reset
//   set         LL load completing: link this address
//   clr         unconditional clear (SC completed or SC failed)
//   clr_match   store completing: clear if it hits the linked word
//   snoop       coherence invalidate
//   snoop_addr  invalidated address
//   addr        current instruction address (for set and match)
//   link_valid  link register valid bit
//   match       link valid and addr is the linked word
module ll_link_reg #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              set,
   input  logic              clr,
   input  logic              clr_match,
   input  logic              snoop,
   input  logic [DATA_W-1:0] snoop_addr,
   input  logic [DATA_W-1:0] addr,
   output logic              link_valid,
   output logic              match
);

   // word-granular compare: byte offset bits are masked off
   localparam logic [DATA_W-1:0] WORD_MASK = {{(DATA_W-2){1'b1}}, 2'b00};

   logic [DATA_W-1:0] link_addr;
   logic              addr_hit;
   logic              snoop_hit;

   always_comb begin
      addr_hit  = ((addr ^ link_addr) & WORD_MASK) == '0;
      snoop_hit = snoop & (((snoop_addr ^ link_addr) & WORD_MASK) == '0);
      match     = link_valid & addr_hit;
   end

   // a snoop hit wins over everything, including a same-cycle LL set
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else begin
         if (set)
            link_addr <= addr;
         if (snoop_hit)
            link_valid <= 1'b0;
         else if (clr || (clr_match && addr_hit))
            link_valid <= 1'b0;
         else if (set)
            link_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage sequencer feeding the MEM/WB register.
// Issues data-cache requests for EX/MEM loads/stores, stalls upstream and
// bubbles MEM/WB until dhit, then releases the result with one mw_EN cycle.
// Ports:
//   CLK, nRST                       clock, asynchronous active-low reset
//   valid_i, dREN_i, dWEN_i         instruction present / load / store
//   ll_i, sc_i                      load-linked / store-conditional
//   addr_i, store_i                 effective address / store data
//   halt_i                          HALT in MEM
//   dhit, dmemload                  cache completion and read data
//   ccinv, ccaddr                   coherence invalidate snoop
//   dmemREN, dmemWEN                cache requests
//   dmemaddr, dmemstore             request address / write data
//   mem_stall                       freeze PC/IF/ID/EX and EX/MEM
//   mw_EN, mw_flush                 MEM/WB enable / bubble insert
//   dmemload_o                      data to MEM/WB
//   halted                          sticky halt
module mem_stage_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LINK_EN = 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              valid_i,
   input  logic              dREN_i,
   input  logic              dWEN_i,
   input  logic              ll_i,
   input  logic              sc_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] store_i,
   input  logic              halt_i,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   input  logic              ccinv,
   input  logic [DATA_W-1:0] ccaddr,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [DATA_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic              mw_EN,
   output logic              mw_flush,
   output logic [DATA_W-1:0] dmemload_o,
   output logic              halted
);

   localparam logic LINK_ON = (LINK_EN != 0);

   mem_state_t        state;
   logic [DATA_W-1:0] load_r;
   logic              sc_r;

   logic memop;
   logic scfail;
   logic start;
   logic complete;
   logic link_valid;
   logic link_match;
   logic link_set;
   logic link_clr;
   logic link_clr_match;

   // nRST gates memop so that outputs show reset values while reset is held,
   // even with a memop still presented on the inputs
   always_comb begin
      memop    = nRST & valid_i & (dREN_i | dWEN_i) & ~halted;
      scfail   = memop & sc_i & LINK_ON & ~link_match;
      start    = (state == IDLE) & memop & ~scfail;
      complete = (state == ACCESS) & dhit;
   end

   always_comb begin
      link_set       = complete & dREN_i & ll_i & LINK_ON;
      link_clr       = (complete & sc_i) | ((state == IDLE) & scfail);
      link_clr_match = complete & dWEN_i;
   end

   ll_link_reg #(
      .DATA_W (DATA_W)
   ) u_link (
      .CLK        (CLK),
      .nRST       (nRST),
      .set        (link_set),
      .clr        (link_clr),
      .clr_match  (link_clr_match),
      .snoop      (ccinv),
      .snoop_addr (ccaddr),
      .addr       (addr_i),
      .link_valid (link_valid),
      .match      (link_match)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         load_r <= '0;
         sc_r   <= 1'b0;
         halted <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i && halt_i)
                  halted <= 1'b1;
               if (start)
                  state <= ACCESS;
            end
            ACCESS: begin
               if (dhit) begin
                  load_r <= dmemload;
                  sc_r   <= sc_i;
                  state  <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      dmemaddr   = addr_i;
      dmemstore  = store_i;
      dmemREN    = 1'b0;
      dmemWEN    = 1'b0;
      mem_stall  = 1'b0;
      mw_flush   = 1'b0;
      mw_EN      = 1'b1;
      dmemload_o = '0;
      case (state)
         IDLE: begin
            if (start) begin
               mem_stall = 1'b1;
               mw_flush  = 1'b1;
               mw_EN     = 1'b0;
            end
         end
         ACCESS: begin
            dmemREN   = dREN_i;
            dmemWEN   = dWEN_i;
            mem_stall = 1'b1;
            mw_flush  = 1'b1;
            mw_EN     = 1'b0;
         end
         DONE: begin
            dmemload_o = sc_r ? {{(DATA_W-1){1'b0}}, 1'b1} : load_r;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        valid_i, dREN_i, dWEN_i, ll_i, sc_i, halt_i;
   logic [31:0] addr_i, store_i;
   logic        dhit;
   logic [31:0] dmemload;
   logic        ccinv;
   logic [31:0] ccaddr;
   logic        dmemREN, dmemWEN, mem_stall, mw_EN, mw_flush, halted;
   logic [31:0] dmemaddr, dmemstore, dmemload_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef struct {
      string       tag;
      logic        chk_res;
      logic [31:0] res;
      int unsigned stall;
      int unsigned ren;
      int unsigned wen;
   } exp_t;

   exp_t sb[$];

   mem_stage_ctrl #(
      .DATA_W  (32),
      .LINK_EN (1)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .valid_i    (valid_i),
      .dREN_i     (dREN_i),
      .dWEN_i     (dWEN_i),
      .ll_i       (ll_i),
      .sc_i       (sc_i),
      .addr_i     (addr_i),
      .store_i    (store_i),
      .halt_i     (halt_i),
      .dhit       (dhit),
      .dmemload   (dmemload),
      .ccinv      (ccinv),
      .ccaddr     (ccaddr),
      .dmemREN    (dmemREN),
      .dmemWEN    (dmemWEN),
      .dmemaddr   (dmemaddr),
      .dmemstore  (dmemstore),
      .mem_stall  (mem_stall),
      .mw_EN      (mw_EN),
      .mw_flush   (mw_flush),
      .dmemload_o (dmemload_o),
      .halted     (halted)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      valid_i = 1'b0; dREN_i = 1'b0; dWEN_i = 1'b0;
      ll_i = 1'b0; sc_i = 1'b0; halt_i = 1'b0;
      addr_i = '0; store_i = '0;
   endtask

   // Drives one instruction, acts as the cache (dhit on the n_hit-th request
   // cycle, 0 = never) and retires it against the scoreboard when mw_EN rises.
   task automatic issue(input string tag, input logic ren, input logic wen,
                        input logic ll, input logic sc,
                        input logic [31:0] a, input logic [31:0] d,
                        input int unsigned n_hit, input logic [31:0] ld,
                        input logic chk_res, input logic [31:0] res,
                        input int unsigned st, input int unsigned nren,
                        input int unsigned nwen);
      exp_t e;
      int unsigned stall_c = 0, flush_c = 0, ren_c = 0, wen_c = 0, req_c = 0;
      logic done = 1'b0;
      e.tag = tag; e.chk_res = chk_res; e.res = res;
      e.stall = st; e.ren = nren; e.wen = nwen;
      sb.push_back(e);
      valid_i = 1'b1; dREN_i = ren; dWEN_i = wen; ll_i = ll; sc_i = sc;
      addr_i = a; store_i = d; halt_i = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge CLK);
         if (mem_stall) stall_c++;
         if (mw_flush)  flush_c++;
         if (dmemREN)   ren_c++;
         if (dmemWEN)   wen_c++;
         if (dmemREN || dmemWEN) begin
            req_c++;
            check({tag, "_addr"}, dmemaddr, a);
            check({tag, "_wdata"}, dmemstore, d);
            if (req_c == n_hit) begin
               dhit = 1'b1;
               dmemload = ld;
            end
         end
         if (mw_EN) begin
            done = 1'b1;
            e = sb.pop_front();
            if (e.chk_res) check({e.tag, "_result"}, dmemload_o, e.res);
            check({e.tag, "_stall"}, stall_c, e.stall);
            check({e.tag, "_flush"}, flush_c, e.stall);
            check({e.tag, "_ren"}, ren_c, e.ren);
            check({e.tag, "_wen"}, wen_c, e.wen);
         end
         @(posedge CLK);
         #1;
         dhit = 1'b0;
         dmemload = 32'hA5A5_0000;
      end
      if (!done) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         void'(sb.pop_front());
      end
      clear_inputs();
   endtask

   task automatic idle_cycle(input string tag, input logic inv, input logic [31:0] ia);
      clear_inputs();
      ccinv = inv; ccaddr = ia;
      @(negedge CLK);
      check({tag, "_mwen"}, mw_EN, 1'b1);
      check({tag, "_stall"}, mem_stall, 1'b0);
      @(posedge CLK);
      #1;
      ccinv = 1'b0; ccaddr = '0;
   endtask

   initial begin
      clear_inputs();
      nRST = 1'b0; dhit = 1'b0; dmemload = '0; ccinv = 1'b0; ccaddr = '0;
      repeat (2) @(negedge CLK);
      check("rst_mwen", mw_EN, 1'b1);
      check("rst_stall", mem_stall, 1'b0);
      check("rst_flush", mw_flush, 1'b0);
      check("rst_ren", dmemREN, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_load", dmemload_o, 32'd0);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      issue("lw",   1, 0, 0, 0, 32'h100, 32'h0,        3, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4, 3, 0);
      issue("sw",   0, 1, 0, 0, 32'h200, 32'h12345678, 1, 32'h0,        0, 32'h0,        2, 0, 1);
      issue("ll1",  1, 0, 1, 0, 32'h300, 32'h0,        2, 32'h55,       1, 32'h55,       3, 2, 0);
      issue("sc1",  0, 1, 0, 1, 32'h300, 32'h5,        1, 32'h0,        1, 32'h1,        2, 0, 1);
      issue("sc2",  0, 1, 0, 1, 32'h300, 32'h5,        1, 32'h0,        1, 32'h0,        0, 0, 0);

      issue("ll2",  1, 0, 1, 0, 32'h300, 32'h0,        1, 32'h77,       1, 32'h77,       2, 1, 0);
      idle_cycle("inv302", 1'b1, 32'h302);
      issue("sc3",  0, 1, 0, 1, 32'h300, 32'h6,        1, 32'h0,        1, 32'h0,        0, 0, 0);

      issue("ll3",  1, 0, 1, 0, 32'h300, 32'h0,        1, 32'h88,       1, 32'h88,       2, 1, 0);
      idle_cycle("inv304", 1'b1, 32'h304);
      issue("sc4",  0, 1, 0, 1, 32'h300, 32'h7,        2, 32'h0,        1, 32'h1,        3, 0, 2);

      // reset in the middle of a load, with a live link
      issue("ll4",  1, 0, 1, 0, 32'h300, 32'h0,        1, 32'h99,       1, 32'h99,       2, 1, 0);
      valid_i = 1'b1; dREN_i = 1'b1; addr_i = 32'h100;
      @(negedge CLK);
      @(negedge CLK);
      check("mid_ren", dmemREN, 1'b1);
      #1 nRST = 1'b0;
      #1;
      check("mrst_ren", dmemREN, 1'b0);
      check("mrst_stall", mem_stall, 1'b0);
      check("mrst_flush", mw_flush, 1'b0);
      check("mrst_mwen", mw_EN, 1'b1);
      check("mrst_load", dmemload_o, 32'd0);
      check("mrst_addr", dmemaddr, 32'h100);
      #1;
      clear_inputs();
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      idle_cycle("post_rst", 1'b0, 32'h0);
      issue("sc_rst", 0, 1, 0, 1, 32'h300, 32'h8,      1, 32'h0,        1, 32'h0,        0, 0, 0);

      // halt
      valid_i = 1'b1; halt_i = 1'b1;
      @(negedge CLK);
      check("halt_pre", halted, 1'b0);
      check("halt_mwen", mw_EN, 1'b1);
      @(posedge CLK);
      #1;
      clear_inputs();
      check("halt_set", halted, 1'b1);
      issue("lw_halt", 1, 0, 0, 0, 32'h100, 32'h0,     1, 32'h1234,     1, 32'h0,        0, 0, 0);
      check("halt_sticky", halted, 1'b1);

      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
